seq_alu: RTL and testbench

- Parametrised, handshaked ALU for the MIPS datapath.
- Carries the existing single-cycle operation set and adds XOR, signed SLT, and iterative unsigned multiply and divide.
- Registers the result and reports Zero, overflow and divide-by-zero flags.
- Sits between the register-read and writeback stages; the control FSM stalls on in_ready.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 70 +++++++
 rtl/seq_alu.sv | 140 ++++++++++++++
 tb/tb_seq_alu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and
// the signed-overflow helper used by ADD/SUB.
package alu_pkg;

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_NOTB  = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULU  = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Signed overflow from operand/result sign bits. For SUB the effective
  // second operand is -B, so its sign is flipped before the usual test.
  function automatic logic add_sub_ovf(input logic a_s, input logic b_s,
                                       input logic r_s, input logic is_sub);
    logic b_eff;
    b_eff = b_s ^ is_sub;
    return (a_s == b_eff) && (r_s != a_s);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One step per cycle for WIDTH cycles after start; done is asserted in
// the cycle whose edge performs the final step, and lo/hi present the
// post-step accumulator so the caller can register them on that edge.
module muldiv_iter #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  logic [2*WIDTH-1:0] acc_q, step_acc;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;

  // One iteration. MUL: add B into the high half when the multiplier LSB
  // is set, then shift right (carry lands in the top bit). DIV: shift the
  // next dividend bit into the remainder and subtract B if it fits; the
  // extra trial bit keeps B==0 from looking like a borrow, so a zero
  // divisor naturally yields all-ones quotient and remainder==A.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, b_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH+1]) step_acc = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                     step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign lo   = step_acc[WIDTH-1:0];
  assign hi   = step_acc[2*WIDTH-1:WIDTH];
  assign dz   = is_div_q && (b_q == '0);

  // Operand latch, iteration counter and accumulator; abort wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      acc_q    <= {{WIDTH{1'b0}}, a};
      b_q      <= b;
      is_div_q <= is_div;
      cnt_q    <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q <= step_acc;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith ops complete on the accept
// edge; MULU/DIVU run on the iterative engine while in_ready is low.
// Results and flags are registered and held until the next out_valid.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] W_hi,
  output logic             Zero,
  output logic             ovf,
  output logic             dz
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d, whi_q, whi_d;
  logic             ovf_q, ovf_d, dz_q, dz_d, ov_q, ov_d;
  logic [WIDTH-1:0] alu_w, sum, diff;
  logic             alu_ovf, is_md, accept, eng_start, eng_done, eng_dz;
  logic [WIDTH-1:0] eng_lo, eng_hi;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !abort;
  assign is_md    = (op == OP_MULU) || (op == OP_DIVU);

  muldiv_iter #(.WIDTH(WIDTH)) u_eng (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (abort),
    .start  (eng_start),
    .is_div (op == OP_DIVU),
    .a      (A),
    .b      (B),
    .done   (eng_done),
    .lo     (eng_lo),
    .hi     (eng_hi),
    .dz     (eng_dz)
  );

  // Single-cycle datapath; unused codes fall back to PASSB.
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    alu_w   = B;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_w   = sum;
        alu_ovf = add_sub_ovf(A[WIDTH-1], B[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        alu_w   = diff;
        alu_ovf = add_sub_ovf(A[WIDTH-1], B[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      OP_AND:  alu_w = A & B;
      OP_OR:   alu_w = A | B;
      OP_NOTB: alu_w = ~B;
      OP_XOR:  alu_w = A ^ B;
      OP_SLT:  alu_w = WIDTH'($signed(A) < $signed(B));
      default: alu_w = B;
    endcase
  end

  // Handshake FSM next state plus next values of the result registers.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    whi_d     = whi_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    ov_d      = 1'b0;
    eng_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_md) begin
            eng_start = 1'b1;
            state_d   = BUSY;
          end else begin
            ov_d  = 1'b1;
            w_d   = alu_w;
            whi_d = '0;
            ovf_d = alu_ovf;
            dz_d  = 1'b0;
          end
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (eng_done) begin
          state_d = IDLE;
          ov_d    = 1'b1;
          w_d     = eng_lo;
          whi_d   = eng_hi;
          ovf_d   = 1'b0;
          dz_d    = eng_dz;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      whi_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      whi_q   <= whi_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign W         = w_q;
  assign W_hi      = whi_q;
  assign Zero      = (w_q == '0);
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed scenarios plus randomized ops checked
// against an arithmetic reference model.
module tb_seq_alu;
  localparam int WD = 16;

  logic          clk = 1'b0, clk_en = 1'b1;
  logic          rst_n, abort, in_valid, in_ready, out_valid, Zero, ovf, dz;
  logic [3:0]    op;
  logic [WD-1:0] A, B, W, W_hi;
  int            n_chk = 0, n_err = 0;

  logic [WD-1:0] e_w, e_wh;
  logic          e_ov, e_dz;
  int            lat, rdy_lo;

  seq_alu #(.WIDTH(WD)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .A(A), .B(B), .out_valid(out_valid),
    .W(W), .W_hi(W_hi), .Zero(Zero), .ovf(ovf), .dz(dz)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the op definitions.
  task automatic model(input logic [3:0] o, input logic [WD-1:0] a, input logic [WD-1:0] b,
                       output logic [WD-1:0] w, output logic [WD-1:0] wh,
                       output logic ov, output logic z);
    int sa, sb, s;
    longint p;
    sa = $signed(a); sb = $signed(b);
    w = b; wh = '0; ov = 1'b0; z = 1'b0; s = 0; p = 0;
    case (o)
      4'd1: begin s = sa + sb; w = a + b; ov = (s > 2**(WD-1) - 1) || (s < -(2**(WD-1))); end
      4'd2: begin s = sa - sb; w = a - b; ov = (s > 2**(WD-1) - 1) || (s < -(2**(WD-1))); end
      4'd3: w = a & b;
      4'd4: w = a | b;
      4'd5: w = ~b;
      4'd6: w = a ^ b;
      4'd7: w = (sa < sb) ? 1 : 0;
      4'd8: begin p = longint'(a) * longint'(b); w = p[WD-1:0]; wh = p[2*WD-1:WD]; end
      4'd9: begin
        if (b == 0) begin w = '1; wh = a; z = 1'b1; end
        else begin w = a / b; wh = a % b; end
      end
      default: w = b;
    endcase
  endtask

  // Starts and ends at a negedge. Presents one op, counts edges (accept
  // edge = 1) until out_valid, optionally pulsing in_valid while busy or
  // raising abort before edge abort_at+1.
  task automatic run_op(input logic [3:0] o, input logic [WD-1:0] a, input logic [WD-1:0] b,
                        input bit pulse, input int abort_at, output int l, output int rl);
    op = o; A = a; B = b; in_valid = 1'b1; l = 0; rl = 0;
    do begin
      @(posedge clk); l++;
      @(negedge clk);
      abort = 1'b0;
      if (!in_ready) rl++;
      in_valid = pulse && l[0] && !out_valid;
      if (abort_at != 0 && l == abort_at) abort = 1'b1;
    end while (!out_valid && l < 40 && !(abort_at != 0 && l > abort_at));
    in_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_W"}, W, 0);
    chk({tag, "_Whi"}, W_hi, 0);
    chk({tag, "_Zero"}, Zero, 1);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_flags"}, {ovf, dz}, 0);
  endtask

  initial begin
    logic [3:0]    o;
    logic [WD-1:0] a, b, mw, mwh;
    logic          mov, mdz;
    int            ab_at, cnt;

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; op = '0; A = '0; B = '0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk_reset("por");

    // Back-to-back single-cycle ops
    op = 4'd1; A = 16'h7FFF; B = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    chk("add_ov", out_valid, 1); chk("add_W", W, 16'h8000); chk("add_ovf", ovf, 1);
    op = 4'd2; A = 16'h0005; B = 16'h0005;
    @(negedge clk);
    chk("sub_ov", out_valid, 1); chk("sub_W", W, 0); chk("sub_Zero", Zero, 1); chk("sub_ovf", ovf, 0);
    op = 4'd7; A = 16'hFFFF; B = 16'h0001;
    @(negedge clk);
    chk("slt_ov", out_valid, 1); chk("slt_W", W, 1); chk("slt_Whi", W_hi, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("slt_pulse", out_valid, 0); chk("slt_hold", W, 1);

    // MULU with in_valid pulses while busy
    run_op(4'd8, 16'h1234, 16'h0100, 1'b1, 0, lat, rdy_lo);
    chk("mul_lat", lat, 17); chk("mul_rdylo", rdy_lo, 16);
    chk("mul_W", W, 16'h3400); chk("mul_Whi", W_hi, 16'h0012); chk("mul_ovf", ovf, 0);
    @(negedge clk);
    chk("mul_pulse", out_valid, 0); chk("mul_noacc", in_ready, 1);

    // DIVU
    run_op(4'd9, 16'd100, 16'd7, 1'b0, 0, lat, rdy_lo);
    chk("div_lat", lat, 17); chk("div_W", W, 16'h000E); chk("div_Whi", W_hi, 16'h0002); chk("div_dz", dz, 0);
    run_op(4'd9, 16'h0055, 16'h0000, 1'b0, 0, lat, rdy_lo);
    chk("dz_lat", lat, 17); chk("dz_W", W, 16'hFFFF); chk("dz_Whi", W_hi, 16'h0055); chk("dz_dz", dz, 1);

    // Abort on busy cycle 5
    run_op(4'd8, 16'hFFFF, 16'hFFFF, 1'b0, 5, lat, rdy_lo);
    chk("ab_lat", lat, 6); chk("ab_ov", out_valid, 0); chk("ab_rdy", in_ready, 1);
    chk("ab_W", W, 16'hFFFF); chk("ab_Whi", W_hi, 16'h0055); chk("ab_dz", dz, 1);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (out_valid) cnt++; end
    chk("ab_quiet", cnt, 0);
    // Op presented together with abort is dropped
    op = 4'd1; A = 16'd9; B = 16'd9; in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("abacc_ov", out_valid, 0); chk("abacc_W", W, 16'hFFFF);
    run_op(4'd1, 16'd2, 16'd3, 1'b0, 0, lat, rdy_lo);
    chk("add5_lat", lat, 1); chk("add5_W", W, 5); chk("add5_Whi", W_hi, 0); chk("add5_dz", dz, 0);

    // Async reset during DIVU busy cycle 8
    op = 4'd9; A = 16'h1234; B = 16'h0003; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_quiet", out_valid, 0);
    run_op(4'd9, 16'd9, 16'd3, 1'b0, 0, lat, rdy_lo);
    chk("d93_lat", lat, 17); chk("d93_W", W, 3); chk("d93_Whi", W_hi, 0);

    // Reset with clock stopped
    clk_en = 1'b0;
    #20 rst_n = 1'b0;
    #3 chk_reset("stop");
    rst_n = 1'b1;
    #7 clk_en = 1'b1;
    @(negedge clk);

    // Randomized ops against the model
    e_w = '0; e_wh = '0; e_ov = 1'b0; e_dz = 1'b0;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = WD'($urandom);
      b = ($urandom % 8 == 0) ? '0 : WD'($urandom);
      ab_at = ((o == 4'd8 || o == 4'd9) && ($urandom % 6 == 0)) ? int'($urandom_range(1, 16)) : 0;
      run_op(o, a, b, 1'($urandom), ab_at, lat, rdy_lo);
      if (ab_at != 0) begin
        chk("r_ab_lat", lat, ab_at + 1); chk("r_ab_ov", out_valid, 0);
      end else begin
        model(o, a, b, mw, mwh, mov, mdz);
        e_w = mw; e_wh = mwh; e_ov = mov; e_dz = mdz;
        chk("r_lat", lat, (o == 4'd8 || o == 4'd9) ? WD + 1 : 1);
        chk("r_ov", out_valid, 1);
      end
      chk("r_W", W, e_w); chk("r_Whi", W_hi, e_wh);
      chk("r_flags", {ovf, dz}, {e_ov, e_dz}); chk("r_Zero", Zero, e_w == '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
